// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with per-bit don't-care mask,
// run-time overlap selection, registered match pulse and saturating match counter.
module seq_detector_param #(
   parameter int unsigned    N             = 4,
   parameter int unsigned    COUNT_WIDTH   = 8,
   parameter logic [N-1:0]   RESET_PATTERN = N'(4'b1101),
   parameter logic [N-1:0]   RESET_MASK    = N'(4'b1111)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   x,
   input  logic                   overlap_en,
   input  logic                   cfg_load,
   input  logic [N-1:0]           cfg_pattern,
   input  logic [N-1:0]           cfg_mask,
   input  logic                   cnt_clr,
   output logic                   y,
   output logic [COUNT_WIDTH-1:0] match_count,
   output logic                   armed
);

   localparam int unsigned    FW        = $clog2(N + 1);
   localparam logic [FW-1:0]  FILL_FULL = FW'(N);
   localparam logic [FW-1:0]  FILL_ARM  = FW'(N - 1);

   logic [N-1:0]  r_hist;
   logic [N-1:0]  r_pattern;
   logic [N-1:0]  r_mask;
   logic [FW-1:0] r_fill;

   logic [N-1:0]  w_hist_next;
   logic [FW-1:0] w_fill_inc;
   logic [FW-1:0] w_fill_next;
   logic          w_accept;
   logic          w_match;

   always_comb begin
      w_accept    = in_valid && !cfg_load;
      w_hist_next = {r_hist[N-2:0], x};
      w_fill_inc  = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FW'(1);
      w_match     = w_accept && (w_fill_inc == FILL_FULL) &&
                    (((w_hist_next ^ r_pattern) & r_mask) == '0);
      // Non-overlap restarts the fill after a hit; cfg_load always restarts it.
      w_fill_next = r_fill;
      if (cfg_load)
         w_fill_next = '0;
      else if (in_valid)
         w_fill_next = (w_match && !overlap_en) ? '0 : w_fill_inc;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hist      <= '0;
         r_fill      <= '0;
         r_pattern   <= RESET_PATTERN;
         r_mask      <= RESET_MASK;
         y           <= 1'b0;
         match_count <= '0;
         armed       <= 1'b0;
      end else begin
         if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_mask    <= cfg_mask;
         end else if (in_valid) begin
            r_hist <= w_hist_next;
         end
         r_fill <= w_fill_next;
         y      <= w_match;
         armed  <= (w_fill_next >= FILL_ARM);
         if (cnt_clr)
            match_count <= w_match ? COUNT_WIDTH'(1) : '0;
         else if (w_match && (match_count != '1))
            match_count <= match_count + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed scenarios then random traffic,
// checked against a bit-queue reference model on two counter widths.
module tb_seq_detector_param;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst, in_valid, x, overlap_en, cfg_load, cnt_clr;
   logic [N-1:0] cfg_pattern, cfg_mask;
   logic         y_a, armed_a, y_b, armed_b;
   logic [7:0]   cnt_a;
   logic [1:0]   cnt_b;

   always #5 clk = ~clk;

   seq_detector_param #(.N(N), .COUNT_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .overlap_en(overlap_en),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .cnt_clr(cnt_clr), .y(y_a), .match_count(cnt_a), .armed(armed_a));

   seq_detector_param #(.N(N), .COUNT_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .overlap_en(overlap_en),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .cnt_clr(cnt_clr), .y(y_b), .match_count(cnt_b), .armed(armed_b));

   typedef struct {
      bit          y;
      bit          armed;
      int unsigned ca;
      int unsigned cb;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: bits accepted since the last restart, newest at the back.
   bit          hq[$];
   bit [N-1:0]  m_pat, m_msk;
   int unsigned m_ca, m_cb;

   function automatic bit window_hit();
      for (int i = 0; i < N; i++)
         if (m_msk[i] && (hq[hq.size()-1-i] != m_pat[i])) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input bit r, input bit iv, input bit xi, input bit ov,
                       input bit cl, input bit [N-1:0] p, input bit [N-1:0] m,
                       input bit cc);
      exp_t e;
      bit   hit;
      @(negedge clk);
      rst = r; in_valid = iv; x = xi; overlap_en = ov;
      cfg_load = cl; cfg_pattern = p; cfg_mask = m; cnt_clr = cc;
      hit = 1'b0;
      if (!r) begin
         hq.delete(); m_pat = 4'b1101; m_msk = 4'b1111; m_ca = 0; m_cb = 0;
      end else begin
         if (cl) begin
            m_pat = p; m_msk = m; hq.delete();
         end else if (iv) begin
            hq.push_back(xi);
            hit = (hq.size() >= N) && window_hit();
            if (hit && !ov) hq.delete();
            while (hq.size() > N) void'(hq.pop_front());
         end
         if (cc) begin
            m_ca = hit ? 1 : 0; m_cb = hit ? 1 : 0;
         end else if (hit) begin
            if (m_ca < 255) m_ca++;
            if (m_cb < 3) m_cb++;
         end
      end
      e.y = hit; e.ca = m_ca; e.cb = m_cb;
      e.armed = r && (hq.size() >= N - 1);
      sb.push_back(e);
   endtask

   task automatic bitv(input bit xi, input bit ov);
      step(1'b1, 1'b1, xi, ov, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic idle(input bit ov);
      step(1'b1, 1'b0, 1'b0, ov, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("y",           y_a,     e.y);
            chk("armed",       armed_a, e.armed);
            chk("match_count", cnt_a,   e.ca);
            chk("y_cw2",       y_b,     e.y);
            chk("count_cw2",   cnt_b,   e.cb);
         end
      end
   end

   initial begin
      bit [6:0] s7;
      bit [3:0] s4;
      rst = 1'b1; in_valid = 1'b0; x = 1'b0; overlap_en = 1'b1;
      cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '0; cnt_clr = 1'b0;

      // overlap: 1101101 -> two hits
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      s7 = 7'b1101101;
      for (int i = 6; i >= 0; i--) bitv(s7[i], 1'b1);

      // non-overlap: one hit, then a fresh 1101 hits again
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 6; i >= 0; i--) bitv(s7[i], 1'b0);
      s4 = 4'b1101;
      for (int i = 3; i >= 0; i--) bitv(s4[i], 1'b0);

      // in_valid gap holds state and keeps armed high
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
      bitv(1'b1, 1'b1); bitv(1'b1, 1'b1); bitv(1'b0, 1'b1);
      idle(1'b1); idle(1'b1); idle(1'b1);
      bitv(1'b1, 1'b1); idle(1'b1);

      // cfg_load with a bit on the same edge, then masked matches
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, 4'b1011, 1'b0);
      for (int i = 3; i >= 0; i--) bitv(s4[i], 1'b0);
      s4 = 4'b1001;
      for (int i = 3; i >= 0; i--) bitv(s4[i], 1'b0);

      // reset mid-sequence aborts the partial match
      bitv(1'b1, 1'b1); bitv(1'b1, 1'b1); bitv(1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
      bitv(1'b1, 1'b1);
      s4 = 4'b1101;
      for (int i = 3; i >= 0; i--) bitv(s4[i], 1'b1);

      // all-don't-care mask: counter saturation and clear-on-match
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      for (int i = 0; i < 10; i++) bitv(1'($urandom), 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 6; i++) bitv(1'($urandom), 1'b0);

      // random traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
              1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0),
              N'($urandom), N'($urandom), ($urandom_range(0, 49) == 0));

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
